// File: rtl/cluster_boot_pkg.sv
// Cluster boot sequencer shared types.
// State encoding and default timing constants.
package cluster_boot_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_CLK_ON  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RUN     = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_RESET   = 3'd6
    } boot_state_e;

    localparam int unsigned DEF_RST_HOLD_CYCLES = 16;
    localparam int unsigned DEF_SETTLE_CYCLES   = 8;
    localparam int unsigned DEF_DRAIN_TIMEOUT   = 1024;
    localparam int unsigned DEF_CNT_WIDTH       = 16;

endpackage

// File: rtl/boot_seq_timer.sv
// Saturating cycle timer shared by the boot sequencer states.
// done_o is high once the count reaches limit_i - 1.
module boot_seq_timer #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 done_o
);

    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q;

    // Count while enabled, hold at all-ones rather than wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign done_o = (cnt_q >= (limit_i - ONE));

endmodule

// File: rtl/cluster_boot_sequencer.sv
// Cluster power-up/power-down sequencer.
// Orders clock enable, reset release, isolation and fetch enable.
module cluster_boot_sequencer
    import cluster_boot_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ctrl_rstn_i,
    input  logic       ctrl_en_sa_boot_i,
    input  logic       ctrl_fetch_en_i,
    input  logic       isolated_i,
    output logic       cluster_clk_en_o,
    output logic       cluster_rstn_o,
    output logic       cluster_en_sa_boot_o,
    output logic       cluster_fetch_en_o,
    output logic       cluster_isolate_o,
    output logic       busy_o,
    output logic [2:0] state_o,
    output logic       timeout_o
);

    boot_state_e          state_q;
    boot_state_e          state_d;
    logic                 tmr_clr;
    logic                 tmr_en;
    logic                 tmr_done;
    logic [CNT_WIDTH-1:0] tmr_limit;

    boot_seq_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .done_o  (tmr_done)
    );

    // Next-state decode and timer limit selection for the current state.
    always_comb begin
        state_d   = state_q;
        tmr_limit = CNT_WIDTH'(RST_HOLD_CYCLES);
        unique case (state_q)
            ST_OFF: begin
                if (ctrl_rstn_i) state_d = ST_CLK_ON;
            end
            ST_CLK_ON: begin
                if (!ctrl_rstn_i)  state_d = ST_OFF;
                else if (tmr_done) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!ctrl_rstn_i)    state_d = ST_DRAIN;
                else if (!isolated_i) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_limit = CNT_WIDTH'(SETTLE_CYCLES);
                if (!ctrl_rstn_i)  state_d = ST_DRAIN;
                else if (tmr_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!ctrl_rstn_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                tmr_limit = CNT_WIDTH'(DRAIN_TIMEOUT);
                if (isolated_i || tmr_done) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (tmr_done) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = (state_q inside {ST_CLK_ON, ST_SETTLE, ST_DRAIN, ST_RESET});
    assign state_o = state_q;

    // State register with every cluster-facing output registered alongside it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q              <= ST_OFF;
            cluster_clk_en_o     <= 1'b0;
            cluster_rstn_o       <= 1'b0;
            cluster_en_sa_boot_o <= 1'b0;
            cluster_fetch_en_o   <= 1'b0;
            cluster_isolate_o    <= 1'b1;
            busy_o               <= 1'b0;
            timeout_o            <= 1'b0;
        end else begin
            state_q            <= state_d;
            cluster_clk_en_o   <= (state_d != ST_OFF);
            cluster_rstn_o     <= (state_d inside {ST_RELEASE, ST_SETTLE,
                                                   ST_RUN, ST_DRAIN});
            cluster_isolate_o  <= !(state_d inside {ST_RELEASE, ST_SETTLE,
                                                    ST_RUN});
            cluster_fetch_en_o <= (state_d == ST_RUN) && ctrl_fetch_en_i;
            busy_o             <= !(state_d inside {ST_OFF, ST_RUN});
            if (state_d == ST_OFF) begin
                cluster_en_sa_boot_o <= 1'b0;
            end else if (state_q == ST_OFF) begin
                cluster_en_sa_boot_o <= ctrl_en_sa_boot_i;
            end
            if ((state_q == ST_DRAIN) && (state_d == ST_RESET) && !isolated_i) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cluster_boot_sequencer.sv
// Directed bench for the cluster boot sequencer.
// Small timing parameters keep every sequence a few cycles long.
module tb_cluster_boot_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       ctrl_rstn_i;
    logic       ctrl_en_sa_boot_i;
    logic       ctrl_fetch_en_i;
    logic       isolated_i;
    logic       cluster_clk_en_o;
    logic       cluster_rstn_o;
    logic       cluster_en_sa_boot_o;
    logic       cluster_fetch_en_o;
    logic       cluster_isolate_o;
    logic       busy_o;
    logic [2:0] state_o;
    logic       timeout_o;

    int checks = 0;
    int fails  = 0;
    logic fetch_seen = 1'b0;
    logic rstn_seen  = 1'b0;
    logic [9:0] obs;
    logic [9:0] exp_v;

    cluster_boot_sequencer #(
        .RST_HOLD_CYCLES (4),
        .SETTLE_CYCLES   (2),
        .DRAIN_TIMEOUT   (8),
        .CNT_WIDTH       (16)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .ctrl_rstn_i          (ctrl_rstn_i),
        .ctrl_en_sa_boot_i    (ctrl_en_sa_boot_i),
        .ctrl_fetch_en_i      (ctrl_fetch_en_i),
        .isolated_i           (isolated_i),
        .cluster_clk_en_o     (cluster_clk_en_o),
        .cluster_rstn_o       (cluster_rstn_o),
        .cluster_en_sa_boot_o (cluster_en_sa_boot_o),
        .cluster_fetch_en_o   (cluster_fetch_en_o),
        .cluster_isolate_o    (cluster_isolate_o),
        .busy_o               (busy_o),
        .state_o              (state_o),
        .timeout_o            (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {cluster_clk_en_o, cluster_rstn_o, cluster_en_sa_boot_o,
                  cluster_fetch_en_o, cluster_isolate_o, busy_o,
                  state_o, timeout_o};

    // Pack expected outputs in the same order as obs.
    function automatic logic [9:0] vec(input logic ce, input logic rn,
                                       input logic sa, input logic fe,
                                       input logic iso, input logic bz,
                                       input logic [2:0] st, input logic to);
        return {ce, rn, sa, fe, iso, bz, st, to};
    endfunction

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            if (cluster_fetch_en_o) fetch_seen = 1'b1;
            if (cluster_rstn_o)     rstn_seen  = 1'b1;
        end
    endtask

    task automatic bring_up();
        ctrl_rstn_i = 1'b1;
        isolated_i  = 1'b1;
        step(5);
        isolated_i  = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        ctrl_rstn_i = 1'b0;
        ctrl_en_sa_boot_i = 1'b0;
        ctrl_fetch_en_i = 1'b0;
        isolated_i = 1'b1;
        step(2);
        exp_v = vec(0, 0, 0, 0, 1, 0, 3'd0, 0);
        if (obs !== exp_v) begin
            $display("FAIL reset: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        rst_ni = 1'b1;
        step();
        if (obs !== exp_v) begin
            $display("FAIL reset_idle: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
    endtask

    task automatic test_power_up();
        ctrl_en_sa_boot_i = 1'b1;
        ctrl_rstn_i = 1'b1;
        step();
        exp_v = vec(1, 0, 1, 0, 1, 1, 3'd1, 0);
        if (obs !== exp_v) begin
            $display("FAIL pu_clk_on: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step(3);
        if (obs !== exp_v) begin
            $display("FAIL pu_hold_end: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        exp_v = vec(1, 1, 1, 0, 0, 1, 3'd2, 0);
        if (obs !== exp_v) begin
            $display("FAIL pu_release: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        if (obs !== exp_v) begin
            $display("FAIL pu_wait_ack: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        isolated_i = 1'b0;
        step();
        exp_v = vec(1, 1, 1, 0, 0, 1, 3'd3, 0);
        if (obs !== exp_v) begin
            $display("FAIL pu_settle: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        if (obs !== exp_v) begin
            $display("FAIL pu_settle2: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        exp_v = vec(1, 1, 1, 0, 0, 0, 3'd4, 0);
        if (obs !== exp_v) begin
            $display("FAIL pu_run: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
    endtask

    task automatic test_fetch_follow();
        ctrl_fetch_en_i = 1'b1;
        exp_v = vec(1, 1, 1, 0, 0, 0, 3'd4, 0);
        if (obs !== exp_v) begin
            $display("FAIL ff_latency: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        exp_v = vec(1, 1, 1, 1, 0, 0, 3'd4, 0);
        if (obs !== exp_v) begin
            $display("FAIL ff_rise: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_en_sa_boot_i = 1'b0;
        step();
        if (obs !== exp_v) begin
            $display("FAIL ff_sa_hold: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_fetch_en_i = 1'b0;
        step();
        exp_v = vec(1, 1, 1, 0, 0, 0, 3'd4, 0);
        if (obs !== exp_v) begin
            $display("FAIL ff_fall: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
    endtask

    task automatic test_shutdown_ack();
        ctrl_fetch_en_i = 1'b1;
        step();
        exp_v = vec(1, 1, 1, 1, 0, 0, 3'd4, 0);
        if (obs !== exp_v) begin
            $display("FAIL sd_pre: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_rstn_i = 1'b0;
        step();
        exp_v = vec(1, 1, 1, 0, 1, 1, 3'd5, 0);
        if (obs !== exp_v) begin
            $display("FAIL sd_drain: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_rstn_i = 1'b1;
        step(2);
        if (obs !== exp_v) begin
            $display("FAIL sd_ignore_rstn: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        isolated_i = 1'b1;
        step();
        exp_v = vec(1, 0, 1, 0, 1, 1, 3'd6, 0);
        if (obs !== exp_v) begin
            $display("FAIL sd_reset: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step(3);
        if (obs !== exp_v) begin
            $display("FAIL sd_reset_hold: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        exp_v = vec(0, 0, 0, 0, 1, 0, 3'd0, 0);
        if (obs !== exp_v) begin
            $display("FAIL sd_off: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_rstn_i = 1'b0;
        ctrl_fetch_en_i = 1'b0;
        step();
        if (obs !== exp_v) begin
            $display("FAIL sd_stay_off: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
    endtask

    task automatic test_drain_timeout();
        ctrl_en_sa_boot_i = 1'b1;
        bring_up();
        exp_v = vec(1, 1, 1, 0, 0, 0, 3'd4, 0);
        if (obs !== exp_v) begin
            $display("FAIL to_run: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_rstn_i = 1'b0;
        step(8);
        exp_v = vec(1, 1, 1, 0, 1, 1, 3'd5, 0);
        if (obs !== exp_v) begin
            $display("FAIL to_drain_last: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        exp_v = vec(1, 0, 1, 0, 1, 1, 3'd6, 1);
        if (obs !== exp_v) begin
            $display("FAIL to_reset: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step(4);
        exp_v = vec(0, 0, 0, 0, 1, 0, 3'd0, 1);
        if (obs !== exp_v) begin
            $display("FAIL to_off: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_en_sa_boot_i = 1'b0;
        bring_up();
        exp_v = vec(1, 1, 0, 0, 0, 0, 3'd4, 1);
        if (obs !== exp_v) begin
            $display("FAIL to_sticky: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
    endtask

    task automatic test_reset_in_run();
        ctrl_fetch_en_i = 1'b1;
        step();
        exp_v = vec(1, 1, 0, 1, 0, 0, 3'd4, 1);
        if (obs !== exp_v) begin
            $display("FAIL rr_pre: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        rst_ni = 1'b0;
        step();
        exp_v = vec(0, 0, 0, 0, 1, 0, 3'd0, 0);
        if (obs !== exp_v) begin
            $display("FAIL rr_reset: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        rst_ni = 1'b1;
        ctrl_rstn_i = 1'b0;
        ctrl_fetch_en_i = 1'b0;
        step();
        if (obs !== exp_v) begin
            $display("FAIL rr_idle: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
    endtask

    task automatic test_abort_clk_on();
        rstn_seen = 1'b0;
        ctrl_en_sa_boot_i = 1'b1;
        ctrl_rstn_i = 1'b1;
        step();
        exp_v = vec(1, 0, 1, 0, 1, 1, 3'd1, 0);
        if (obs !== exp_v) begin
            $display("FAIL ac_c1: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step();
        if (obs !== exp_v) begin
            $display("FAIL ac_c2: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_rstn_i = 1'b0;
        step();
        exp_v = vec(0, 0, 0, 0, 1, 0, 3'd0, 0);
        if (obs !== exp_v) begin
            $display("FAIL ac_off: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step(6);
        if (rstn_seen !== 1'b0) begin
            $display("FAIL ac_rstn_low: got %b want 0", rstn_seen); fails++;
        end
        checks++;
    endtask

    task automatic test_abort_settle();
        fetch_seen = 1'b0;
        ctrl_fetch_en_i = 1'b1;
        ctrl_rstn_i = 1'b1;
        isolated_i = 1'b1;
        step(5);
        exp_v = vec(1, 1, 1, 0, 0, 1, 3'd2, 0);
        if (obs !== exp_v) begin
            $display("FAIL as_release: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        isolated_i = 1'b0;
        step();
        exp_v = vec(1, 1, 1, 0, 0, 1, 3'd3, 0);
        if (obs !== exp_v) begin
            $display("FAIL as_settle: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        ctrl_rstn_i = 1'b0;
        step();
        exp_v = vec(1, 1, 1, 0, 1, 1, 3'd5, 0);
        if (obs !== exp_v) begin
            $display("FAIL as_drain: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        isolated_i = 1'b1;
        step();
        exp_v = vec(1, 0, 1, 0, 1, 1, 3'd6, 0);
        if (obs !== exp_v) begin
            $display("FAIL as_reset: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        step(4);
        exp_v = vec(0, 0, 0, 0, 1, 0, 3'd0, 0);
        if (obs !== exp_v) begin
            $display("FAIL as_off: got %b want %b", obs, exp_v); fails++;
        end
        checks++;
        if (fetch_seen !== 1'b0) begin
            $display("FAIL as_no_fetch: got %b want 0", fetch_seen); fails++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_fetch_follow();
        test_shutdown_ack();
        test_drain_timeout();
        test_reset_in_run();
        test_abort_clk_on();
        test_abort_settle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
